// File: rtl/jt10_cen_burst_mc_pkg.sv
// Shared definitions for the clock-enable burst generator.
package jt10_cen_pkg;

   // Behaviour of a start edge that arrives while a burst is still running.
   localparam int CEN_RETRIG_IGNORE = 0;
   localparam int CEN_RETRIG_RELOAD = 1;

   // Per-channel sequencing state.
   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

endpackage

// File: rtl/jt10_cen_burst_mc_if.sv
// Bundle of burst control inputs and per-channel status outputs.
interface jt10_cen_burst_mc_if #(
   parameter int CH   = 1,
   parameter int CNTW = 3
);
   logic                cen;
   logic [CH-1:0]       start;
   logic [CH*CNTW-1:0]  len;
   logic [CH-1:0]       abort;
   logic [CH-1:0]       cen_out;
   logic [CH-1:0]       busy;
   logic [CH-1:0]       done;
   logic [CH-1:0]       miss;

   modport master (
      output cen, start, len, abort,
      input  cen_out, busy, done, miss
   );

   modport slave (
      input  cen, start, len, abort,
      output cen_out, busy, done, miss
   );
endinterface

// File: rtl/jt10_cen_burst_mc_ch.sv
// One burst channel: gates the shared cen for a programmed number of pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CH_IDLE | no burst; waiting for a start edge seen on a cen cycle
// CH_RUN  | burst active; cnt holds the cen pulses still to be passed
module jt10_cen_burst_ch
   import jt10_cen_pkg::*;
#(
   parameter int CNTW   = 3,
   parameter int RETRIG = CEN_RETRIG_IGNORE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            start,
   input  logic [CNTW-1:0] len,
   input  logic            abort,
   output logic            cen_out,
   output logic            busy,
   output logic            done,
   output logic            miss
);

   ch_state_e       state;
   logic [CNTW-1:0] cnt;
   logic            last_start;
   logic            start_edge;

   assign start_edge = cen & start & ~last_start;
   assign busy       = (state == CH_RUN);
   // Gate only from registered busy so start never reaches cen_out combinationally.
   assign cen_out    = cen & busy & ~abort;

   // Edge history, burst counter and status flags; abort outranks everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CH_IDLE;
         cnt        <= '0;
         last_start <= 1'b1;   // a start held high through reset is not an edge
         done       <= 1'b0;
         miss       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cen)
            last_start <= start;

         if (abort) begin
            state <= CH_IDLE;
            cnt   <= '0;
            miss  <= 1'b0;
         end else if (state == CH_IDLE) begin
            if (start_edge) begin
               if (len != '0) begin
                  cnt   <= len;
                  state <= CH_RUN;
               end else begin
                  done <= 1'b1;
               end
            end
         end else if (start_edge && (RETRIG == CEN_RETRIG_RELOAD)) begin
            // This cycle's pulse closes the old burst; the new one starts counting next cen.
            if (len != '0) begin
               cnt <= len;
            end else begin
               state <= CH_IDLE;
               cnt   <= '0;
               done  <= 1'b1;
            end
         end else if (cen) begin
            if (start_edge)
               miss <= 1'b1;
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
               state <= CH_IDLE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/jt10_cen_burst_mc.sv
// Multi-channel cen burst generator: slices the buses and replicates one channel.
module jt10_cen_burst_mc
   import jt10_cen_pkg::*;
#(
   parameter int CH     = 1,
   parameter int CNTW   = 3,
   parameter int RETRIG = CEN_RETRIG_IGNORE
) (
   input  logic              clk,
   input  logic              rst,
   jt10_cen_burst_mc_if.slave bus
);

   logic [CH-1:0] cen_out_w;
   logic [CH-1:0] busy_w;
   logic [CH-1:0] done_w;
   logic [CH-1:0] miss_w;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      jt10_cen_burst_ch #(
         .CNTW   (CNTW),
         .RETRIG (RETRIG)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .cen     (bus.cen),
         .start   (bus.start[i]),
         .len     (bus.len[i*CNTW +: CNTW]),
         .abort   (bus.abort[i]),
         .cen_out (cen_out_w[i]),
         .busy    (busy_w[i]),
         .done    (done_w[i]),
         .miss    (miss_w[i])
      );
   end

   assign bus.cen_out = cen_out_w;
   assign bus.busy    = busy_w;
   assign bus.done    = done_w;
   assign bus.miss    = miss_w;

endmodule
